mlaccel_sspi_phy: RTL and testbench

Parametrised SPI slave bit-level engine for the accelerator's host port, successor to the single-lane MOSI/MISO front-end. Oversamples SPI pins in the `clock` domain, rejects short clock glitches, and supports single (full-duplex), dual and quad lane modes selected per byte. Presents byte streams to the command decoder (`rx_*`) and from it (`tx_*`), plus framing and underrun status.

---
 rtl/mlaccel_sspi_phy.sv | 272 +++++++++++++++++++++++++++
 tb/tb_mlaccel_sspi_phy.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mlaccel_sspi_phy.sv
// SPI slave bit engine for the host port: mode 3, oversampled pins with a glitch filter on
// spi_clk, and single/dual/quad lanes chosen per byte. Bytes go to the command decoder on
// rx_* and come from it on tx_*.
module mlaccel_sspi_phy #(
  parameter int unsigned FILTER_LEN = 2,
  parameter logic [7:0]  IDLE_BYTE  = 8'hFF
) (
  input  logic       i_clock,
  input  logic       i_reset,
  input  logic       i_spi_csb,
  input  logic       i_spi_clk,
  input  logic [3:0] i_spi_io_in,
  output logic [3:0] o_spi_io_out,
  output logic [3:0] o_spi_io_oe,
  input  logic [1:0] i_lane_mode,
  input  logic       i_lane_dir,
  output logic       o_rx_valid,
  output logic [7:0] o_rx_data,
  output logic       o_rx_first,
  input  logic       i_tx_valid,
  input  logic [7:0] i_tx_data,
  output logic       o_tx_ready,
  output logic       o_tx_underrun,
  output logic       o_xfer_active,
  output logic       o_xfer_end
);

  localparam logic [1:0] FiltMax = 2'(FILTER_LEN - 1);

  // Normalised lane modes; the reserved encoding folds onto single.
  localparam logic [1:0] LnSingle = 2'b00;
  localparam logic [1:0] LnDual   = 2'b01;
  localparam logic [1:0] LnQuad   = 2'b10;

  typedef enum logic [1:0] {StDisarmed, StIdle, StActive} state_e;

  logic       r_csb_s1, r_csb_s2;
  logic       r_sck_s1, r_sck_s2;
  logic [3:0] r_io_s1, r_io_s2;

  logic       r_sck_filt;
  logic [1:0] r_filt_cnt;
  logic       r_rise, r_fall;

  state_e     r_state;
  logic [1:0] r_mode;
  logic       r_dir;
  logic [2:0] r_bit_cnt;
  logic       r_first;
  logic [7:0] r_rx_sh;
  logic [7:0] r_tx_sh;
  logic [3:0] r_io_out;
  logic [3:0] r_oe;
  logic       r_rx_valid;
  logic [7:0] r_rx_data;
  logic       r_rx_first;
  logic       r_tx_ready;
  logic       r_underrun;
  logic       r_active;
  logic       r_xfer_end;

  logic [1:0] w_mode_in;
  logic       w_tx_en_in;
  logic       w_rx_en;
  logic       w_tx_en;
  logic [2:0] w_last_cnt;
  logic [7:0] w_rx_next;
  logic [7:0] w_tx_byte;
  logic [3:0] w_load_out;
  logic [7:0] w_load_sh;
  logic [3:0] w_shift_out;
  logic [7:0] w_shift_sh;
  logic [3:0] w_oe_in;

  // Two-flop synchronisers. CSB resets to 0 so a CSB still held low after reset is never
  // mistaken for a fresh frame; the engine waits until it genuinely sees CSB high.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_csb_s1 <= 1'b0;
      r_csb_s2 <= 1'b0;
      r_sck_s1 <= 1'b1;
      r_sck_s2 <= 1'b1;
      r_io_s1  <= 4'h0;
      r_io_s2  <= 4'h0;
    end else begin
      r_csb_s1 <= i_spi_csb;
      r_csb_s2 <= r_csb_s1;
      r_sck_s1 <= i_spi_clk;
      r_sck_s2 <= r_sck_s1;
      r_io_s1  <= i_spi_io_in;
      r_io_s2  <= r_io_s1;
    end
  end

  // spi_clk filter: accept a new level only after FILTER_LEN consecutive differing samples.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_sck_filt <= 1'b1;
      r_filt_cnt <= 2'd0;
      r_rise     <= 1'b0;
      r_fall     <= 1'b0;
    end else begin
      r_rise <= 1'b0;
      r_fall <= 1'b0;
      if (r_sck_s2 != r_sck_filt) begin
        if (r_filt_cnt == FiltMax) begin
          r_sck_filt <= r_sck_s2;
          r_filt_cnt <= 2'd0;
          r_rise     <= r_sck_s2;
          r_fall     <= ~r_sck_s2;
        end else begin
          r_filt_cnt <= r_filt_cnt + 2'd1;
        end
      end else begin
        r_filt_cnt <= 2'd0;
      end
    end
  end

  // Lane decode for the byte about to start (live inputs) and the byte in flight (latched).
  always_comb begin
    w_mode_in  = (i_lane_mode == 2'b11) ? LnSingle : i_lane_mode;
    w_tx_en_in = (w_mode_in == LnSingle) || i_lane_dir;
    w_rx_en    = (r_mode == LnSingle) || !r_dir;
    w_tx_en    = (r_mode == LnSingle) || r_dir;
    w_tx_byte  = i_tx_valid ? i_tx_data : IDLE_BYTE;
    case (r_mode)
      LnDual: begin
        w_last_cnt = 3'd3;
        w_rx_next  = {r_rx_sh[5:0], r_io_s2[1:0]};
      end
      LnQuad: begin
        w_last_cnt = 3'd1;
        w_rx_next  = {r_rx_sh[3:0], r_io_s2[3:0]};
      end
      default: begin
        w_last_cnt = 3'd7;
        w_rx_next  = {r_rx_sh[6:0], r_io_s2[0]};
      end
    endcase
  end

  // Tx lane mapping: first bits of a freshly loaded byte, and following bits mid-byte.
  always_comb begin
    case (w_mode_in)
      LnDual: begin
        w_load_out = {2'b00, w_tx_byte[7:6]};
        w_load_sh  = {w_tx_byte[5:0], 2'b00};
        w_oe_in    = i_lane_dir ? 4'b0011 : 4'b0000;
      end
      LnQuad: begin
        w_load_out = w_tx_byte[7:4];
        w_load_sh  = {w_tx_byte[3:0], 4'h0};
        w_oe_in    = i_lane_dir ? 4'b1111 : 4'b0000;
      end
      default: begin
        w_load_out = {2'b00, w_tx_byte[7], 1'b0};
        w_load_sh  = {w_tx_byte[6:0], 1'b0};
        w_oe_in    = 4'b0010;
      end
    endcase
    case (r_mode)
      LnDual: begin
        w_shift_out = {2'b00, r_tx_sh[7:6]};
        w_shift_sh  = {r_tx_sh[5:0], 2'b00};
      end
      LnQuad: begin
        w_shift_out = r_tx_sh[7:4];
        w_shift_sh  = {r_tx_sh[3:0], 4'h0};
      end
      default: begin
        w_shift_out = {2'b00, r_tx_sh[7], 1'b0};
        w_shift_sh  = {r_tx_sh[6:0], 1'b0};
      end
    endcase
  end

  // Frame FSM plus bit engine; every output is registered here.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state    <= StDisarmed;
      r_mode     <= LnSingle;
      r_dir      <= 1'b0;
      r_bit_cnt  <= 3'd0;
      r_first    <= 1'b0;
      r_rx_sh    <= 8'h00;
      r_tx_sh    <= 8'h00;
      r_io_out   <= 4'h0;
      r_oe       <= 4'h0;
      r_rx_valid <= 1'b0;
      r_rx_data  <= 8'h00;
      r_rx_first <= 1'b0;
      r_tx_ready <= 1'b0;
      r_underrun <= 1'b0;
      r_active   <= 1'b0;
      r_xfer_end <= 1'b0;
    end else begin
      r_rx_valid <= 1'b0;
      r_tx_ready <= 1'b0;
      r_xfer_end <= 1'b0;
      case (r_state)
        StDisarmed: begin
          if (r_csb_s2) r_state <= StIdle;
        end
        StIdle: begin
          if (!r_csb_s2) begin
            r_state    <= StActive;
            r_active   <= 1'b1;
            r_bit_cnt  <= 3'd0;
            r_first    <= 1'b1;
            r_underrun <= 1'b0;
            r_mode     <= w_mode_in;
            r_dir      <= i_lane_dir;
            r_oe       <= w_oe_in;
          end
        end
        StActive: begin
          if (r_csb_s2) begin
            // Any partial byte is simply abandoned; the counter restarts at the next frame.
            r_state    <= StIdle;
            r_active   <= 1'b0;
            r_oe       <= 4'h0;
            r_xfer_end <= 1'b1;
          end else if (r_rise) begin
            if (w_rx_en) r_rx_sh <= w_rx_next;
            if (r_bit_cnt == w_last_cnt) begin
              r_bit_cnt <= 3'd0;
              if (w_rx_en) begin
                r_rx_valid <= 1'b1;
                r_rx_data  <= w_rx_next;
                r_rx_first <= r_first;
                r_first    <= 1'b0;
              end
            end else begin
              r_bit_cnt <= r_bit_cnt + 3'd1;
            end
          end else if (r_fall) begin
            if (r_bit_cnt == 3'd0) begin
              // Byte boundary: pick up the lane config and, if this byte transmits, new data.
              r_mode <= w_mode_in;
              r_dir  <= i_lane_dir;
              r_oe   <= w_oe_in;
              if (w_tx_en_in) begin
                r_io_out <= w_load_out;
                r_tx_sh  <= w_load_sh;
                if (i_tx_valid) r_tx_ready <= 1'b1;
                else            r_underrun <= 1'b1;
              end else begin
                r_io_out <= 4'h0;
              end
            end else if (w_tx_en) begin
              r_io_out <= w_shift_out;
              r_tx_sh  <= w_shift_sh;
            end
          end
        end
        default: r_state <= StDisarmed;
      endcase
    end
  end

  assign o_spi_io_out  = r_io_out;
  assign o_spi_io_oe   = r_oe;
  assign o_rx_valid    = r_rx_valid;
  assign o_rx_data     = r_rx_data;
  assign o_rx_first    = r_rx_first;
  assign o_tx_ready    = r_tx_ready;
  assign o_tx_underrun = r_underrun;
  assign o_xfer_active = r_active;
  assign o_xfer_end    = r_xfer_end;

endmodule

// File: tb/tb_mlaccel_sspi_phy.sv
// Scoreboard bench for mlaccel_sspi_phy: a host model drives SPI mode 3 frames, expected
// rx/tx bytes are queued when a frame is issued and monitors compare as the DUT responds.
module tb_mlaccel_sspi_phy;

  localparam int HALF  = 8;
  localparam int SETUP = 8;

  logic       clk;
  logic       rst;
  logic       csb, sck;
  logic [3:0] io_in, io_out, io_oe;
  logic [1:0] lane_mode;
  logic       lane_dir;
  logic       rx_valid, rx_first;
  logic [7:0] rx_data;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_ready, tx_underrun, xfer_active, xfer_end;

  mlaccel_sspi_phy #(.FILTER_LEN(2), .IDLE_BYTE(8'hFF)) dut (
    .i_clock      (clk),
    .i_reset      (rst),
    .i_spi_csb    (csb),
    .i_spi_clk    (sck),
    .i_spi_io_in  (io_in),
    .o_spi_io_out (io_out),
    .o_spi_io_oe  (io_oe),
    .i_lane_mode  (lane_mode),
    .i_lane_dir   (lane_dir),
    .o_rx_valid   (rx_valid),
    .o_rx_data    (rx_data),
    .o_rx_first   (rx_first),
    .i_tx_valid   (tx_valid),
    .i_tx_data    (tx_data),
    .o_tx_ready   (tx_ready),
    .o_tx_underrun(tx_underrun),
    .o_xfer_active(xfer_active),
    .o_xfer_end   (xfer_end)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] d;
    logic       f;
  } rx_t;

  int         n_tests = 0;
  int         n_fail  = 0;
  int         n_ready = 0;
  int         n_end   = 0;
  rx_t        q_rx_exp[$];
  logic [7:0] q_tx_exp[$];
  logic [7:0] q_tx_got[$];
  logic [7:0] q_feed[$];

  int         f_n;
  logic [1:0] f_mode[8];
  logic       f_dir[8];
  logic [7:0] f_data[8];
  bit         f_glitch;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, got, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Decoder-side feeder: presents the head of q_feed and retires it on tx_ready.
  initial begin
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    forever begin
      @(negedge clk);
      if (tx_ready && q_feed.size() != 0) void'(q_feed.pop_front());
      tx_valid = (q_feed.size() != 0);
      tx_data  = (q_feed.size() != 0) ? q_feed[0] : 8'h00;
    end
  end

  // Monitor: compares every rx_valid and every host-captured tx byte against the queues.
  initial begin
    rx_t        e;
    logic [7:0] g, x;
    forever begin
      @(negedge clk);
      if (rx_valid) begin
        if (q_rx_exp.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL rx_unexpected: got rx_valid with data %02h, required none", rx_data);
        end else begin
          e = q_rx_exp.pop_front();
          check("rx_data", {24'h0, rx_data}, {24'h0, e.d});
          check("rx_first", {31'h0, rx_first}, {31'h0, e.f});
        end
      end
      if (tx_ready) n_ready++;
      if (xfer_end) n_end++;
      while (q_tx_got.size() != 0) begin
        g = q_tx_got.pop_front();
        if (q_tx_exp.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL tx_unexpected: got host byte %02h, required none", g);
        end else begin
          x = q_tx_exp.pop_front();
          check("tx_byte", {24'h0, g}, {24'h0, x});
        end
      end
    end
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: got no finish, required finish within time limit");
    $fatal(1, "watchdog");
  end

  // One host byte (or its first 'lim' clock periods). Host drives on falling, samples on rising.
  task automatic spi_byte(input logic [1:0] mode, input logic dir, input logic [7:0] mosi,
                          input int lim, input bit glitch, input bit act,
                          output logic [7:0] miso);
    bit         single;
    int         k;
    logic [3:0] mask, chunk, rnd, exp_oe;
    logic [7:0] tmp;
    single = (mode == 2'b00) || (mode == 2'b11);
    k      = single ? 1 : ((mode == 2'b01) ? 2 : 4);
    mask   = single ? 4'h1 : ((mode == 2'b01) ? 4'h3 : 4'hF);
    exp_oe = single ? 4'b0010 : (dir ? mask : 4'h0);
    if (!act) exp_oe = 4'h0;
    lane_mode = mode;
    lane_dir  = dir;
    miso      = 8'h00;
    for (int s = 0; s < 8 / k && s < lim; s++) begin
      sck   = 1'b0;
      tmp   = mosi >> (8 - k * (s + 1));
      chunk = tmp[3:0] & mask;
      rnd   = 4'($urandom);
      io_in = (single || !dir) ? ((rnd & ~mask) | chunk) : rnd;
      wait_clks(HALF);
      tmp   = {4'h0, (single ? {3'b000, io_out[1]} : (io_out & mask))};
      miso  = 8'((miso << k) | tmp);
      check("oe", {28'h0, io_oe}, {28'h0, exp_oe});
      sck = 1'b1;
      if (glitch) begin
        wait_clks(HALF / 2);
        sck = 1'b0;
        wait_clks(1);
        sck = 1'b1;
        wait_clks(HALF - HALF / 2 - 1);
      end else begin
        wait_clks(HALF);
      end
    end
  endtask

  // Issue a frame from f_*: derive expectations from the byte list and feed, then drive it.
  task automatic run_frame();
    logic [7:0] feed[$];
    logic [7:0] got;
    rx_t        e;
    int         j, nrx, nfeed;
    bit         single;
    feed  = q_feed;
    nfeed = feed.size();
    j     = 0;
    nrx   = 0;
    for (int i = 0; i < f_n; i++) begin
      single = (f_mode[i] == 2'b00) || (f_mode[i] == 2'b11);
      if (single || !f_dir[i]) begin
        e.d = f_data[i];
        e.f = (nrx == 0);
        q_rx_exp.push_back(e);
        nrx++;
      end
      if (single || f_dir[i]) begin
        q_tx_exp.push_back((j < nfeed) ? feed[j] : 8'hFF);
        j++;
      end
    end
    n_ready   = 0;
    n_end     = 0;
    lane_mode = f_mode[0];
    lane_dir  = f_dir[0];
    csb       = 1'b0;
    wait_clks(SETUP);
    check("xfer_active_start", {31'h0, xfer_active}, 32'h1);
    check("underrun_cleared", {31'h0, tx_underrun}, 32'h0);
    for (int i = 0; i < f_n; i++) begin
      single = (f_mode[i] == 2'b00) || (f_mode[i] == 2'b11);
      spi_byte(f_mode[i], f_dir[i], f_data[i], 8, f_glitch, 1'b1, got);
      if (single || f_dir[i]) q_tx_got.push_back(got);
    end
    wait_clks(SETUP);
    csb = 1'b1;
    wait_clks(20);
    check("tx_ready_count", n_ready, (j < nfeed) ? j : nfeed);
    check("underrun_end", {31'h0, tx_underrun}, {31'h0, (j > nfeed)});
    check("xfer_end_count", n_end, 1);
    check("xfer_active_end", {31'h0, xfer_active}, 32'h0);
    check("oe_end", {28'h0, io_oe}, 32'h0);
    check("rx_drain", q_rx_exp.size(), 0);
    check("tx_drain", q_tx_exp.size(), 0);
    q_feed.delete();
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_io_out"}, {28'h0, io_out}, 32'h0);
    check({tag, "_oe"}, {28'h0, io_oe}, 32'h0);
    check({tag, "_rx_valid"}, {31'h0, rx_valid}, 32'h0);
    check({tag, "_rx_data"}, {24'h0, rx_data}, 32'h0);
    check({tag, "_rx_first"}, {31'h0, rx_first}, 32'h0);
    check({tag, "_tx_ready"}, {31'h0, tx_ready}, 32'h0);
    check({tag, "_underrun"}, {31'h0, tx_underrun}, 32'h0);
    check({tag, "_active"}, {31'h0, xfer_active}, 32'h0);
    check({tag, "_xfer_end"}, {31'h0, xfer_end}, 32'h0);
  endtask

  initial begin
    logic [7:0] got;
    rx_t        e;
    rst       = 1'b1;
    csb       = 1'b1;
    sck       = 1'b1;
    io_in     = 4'h0;
    lane_mode = 2'b00;
    lane_dir  = 1'b0;
    f_glitch  = 1'b0;
    wait_clks(4);
    check_reset_vals("reset");
    rst = 1'b0;
    wait_clks(6);

    // Single mode, two bytes each way.
    f_n = 2;
    f_mode[0] = 2'b00; f_dir[0] = 1'b0; f_data[0] = 8'h21;
    f_mode[1] = 2'b00; f_dir[1] = 1'b0; f_data[1] = 8'hA5;
    q_feed.push_back(8'h3C);
    q_feed.push_back(8'hC3);
    run_frame();

    // Quad receive then quad transmit within one frame.
    f_n = 2;
    f_mode[0] = 2'b10; f_dir[0] = 1'b0; f_data[0] = 8'hA5;
    f_mode[1] = 2'b10; f_dir[1] = 1'b1; f_data[1] = 8'h00;
    q_feed.push_back(8'h96);
    run_frame();

    // Dual receive, dual transmit, then reserved mode behaving as single.
    f_n = 3;
    f_mode[0] = 2'b01; f_dir[0] = 1'b0; f_data[0] = 8'h6B;
    f_mode[1] = 2'b01; f_dir[1] = 1'b1; f_data[1] = 8'h00;
    f_mode[2] = 2'b11; f_dir[2] = 1'b1; f_data[2] = 8'hD2;
    q_feed.push_back(8'h4E);
    q_feed.push_back(8'h17);
    run_frame();

    // Glitched clock with nothing to send: idle byte and sticky underrun.
    f_n = 1;
    f_mode[0] = 2'b00; f_dir[0] = 1'b0; f_data[0] = 8'h5A;
    f_glitch = 1'b1;
    run_frame();
    f_glitch = 1'b0;

    // CSB rises after five bits: no byte, one xfer_end, outputs released.
    n_end     = 0;
    lane_mode = 2'b00;
    lane_dir  = 1'b0;
    csb       = 1'b0;
    wait_clks(SETUP);
    spi_byte(2'b00, 1'b0, 8'hE7, 5, 1'b0, 1'b1, got);
    wait_clks(SETUP);
    csb = 1'b1;
    wait_clks(20);
    check("partial_xfer_end", n_end, 1);
    check("partial_oe", {28'h0, io_oe}, 32'h0);
    check("partial_active", {31'h0, xfer_active}, 32'h0);
    check("partial_underrun", {31'h0, tx_underrun}, 32'h1);
    f_n = 1;
    f_mode[0] = 2'b00; f_dir[0] = 1'b0; f_data[0] = 8'h81;
    q_feed.push_back(8'h55);
    run_frame();

    // Reset mid-byte, then host keeps clocking with CSB low: engine must stay quiet.
    lane_mode = 2'b00;
    csb       = 1'b0;
    wait_clks(SETUP);
    spi_byte(2'b00, 1'b0, 8'h3A, 3, 1'b0, 1'b1, got);
    rst = 1'b1;
    wait_clks(3);
    rst = 1'b0;
    wait_clks(2);
    check_reset_vals("midreset");
    n_end = 0;
    spi_byte(2'b00, 1'b0, 8'hC6, 8, 1'b0, 1'b0, got);
    wait_clks(10);
    check_reset_vals("disarmed");
    csb = 1'b1;
    wait_clks(20);
    check("no_end_after_reset", n_end, 0);
    f_n = 1;
    f_mode[0] = 2'b00; f_dir[0] = 1'b0; f_data[0] = 8'h9D;
    run_frame();

    // Randomised frames.
    for (int fr = 0; fr < 8; fr++) begin
      int nf;
      f_n = 1 + int'($urandom_range(2, 0));
      for (int i = 0; i < f_n; i++) begin
        f_mode[i] = 2'($urandom);
        f_dir[i]  = 1'($urandom);
        f_data[i] = 8'($urandom);
      end
      nf = int'($urandom_range(f_n, 0));
      for (int i = 0; i < nf; i++) q_feed.push_back(8'($urandom));
      run_frame();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
